// File: rtl/sp_enable_gen.sv
// Clock-enable strobe generator: one-cycle SP every DIV+1 clocks for a
// programmed number of pulses (BURST) or continuously when BURST is zero.
module sp_enable_gen #(
  parameter int CW = 8,
  parameter int BW = 8
) (
  input  logic          CK,
  input  logic          RSTN,
  input  logic          START,
  input  logic          ABORT,
  input  logic          HOLD,
  input  logic [CW-1:0] DIV,
  input  logic [BW-1:0] BURST,
  output logic          SP,
  output logic          BUSY,
  output logic          DONE,
  output logic [BW-1:0] PCNT,
  output logic [1:0]    dbg_state
);

  // Control protocol: START is a level request taken only in IDLE at a
  // clock edge where ABORT is low; ABORT wins over everything else in RUN.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_LAST = 2'd2
  } state_t;

  localparam logic [CW-1:0] DIV_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [BW-1:0] CNT_ONE = {{(BW-1){1'b0}}, 1'b1};

  state_t        state_q, state_n;
  logic [CW-1:0] divcnt_q, divcnt_n;
  logic [CW-1:0] div_l_q, div_l_n;
  logic [BW-1:0] burst_l_q, burst_l_n;
  logic [BW-1:0] pcnt_q, pcnt_n;
  logic [BW-1:0] pcnt_inc;
  logic          sp_q, sp_n;

  assign pcnt_inc = pcnt_q + CNT_ONE;

  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      state_q   <= S_IDLE;
      divcnt_q  <= '0;
      div_l_q   <= '0;
      burst_l_q <= '0;
      pcnt_q    <= '0;
      sp_q      <= 1'b0;
    end else begin
      state_q   <= state_n;
      divcnt_q  <= divcnt_n;
      div_l_q   <= div_l_n;
      burst_l_q <= burst_l_n;
      pcnt_q    <= pcnt_n;
      sp_q      <= sp_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    divcnt_n  = divcnt_q;
    div_l_n   = div_l_q;
    burst_l_n = burst_l_q;
    pcnt_n    = pcnt_q;
    sp_n      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (START && !ABORT) begin
          div_l_n   = DIV;
          burst_l_n = BURST;
          divcnt_n  = '0;
          pcnt_n    = '0;
          state_n   = S_RUN;
        end
      end
      S_RUN: begin
        if (ABORT) begin
          state_n = S_IDLE;
        end else if (!HOLD) begin
          if (divcnt_q == div_l_q) begin
            divcnt_n = '0;
            sp_n     = 1'b1;
            pcnt_n   = pcnt_inc;
            // A zero burst length never terminates; PCNT just wraps.
            if ((burst_l_q != '0) && (pcnt_inc == burst_l_q)) state_n = S_LAST;
          end else begin
            divcnt_n = divcnt_q + DIV_ONE;
          end
        end
      end
      S_LAST: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  assign SP        = sp_q;
  assign BUSY      = (state_q != S_IDLE);
  assign DONE      = (state_q == S_LAST);
  assign PCNT      = pcnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sp_enable_gen.sv
// Bench for sp_enable_gen: randomized bursts predicted from pulse-count
// arithmetic, pulses checked by a monitor against an expected queue.
module tb_sp_enable_gen;

  localparam int CW = 8;
  localparam int BW = 4;
  localparam int RW = 32 + BW + 1;

  logic          CK;
  logic          RSTN;
  logic          START;
  logic          ABORT;
  logic          HOLD;
  logic [CW-1:0] DIV;
  logic [BW-1:0] BURST;
  logic          SP;
  logic          BUSY;
  logic          DONE;
  logic [BW-1:0] PCNT;
  logic [1:0]    dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_pcnt = 0;
  logic [RW-1:0] exp_q[$];

  sp_enable_gen #(.CW(CW), .BW(BW)) dut (
    .CK(CK), .RSTN(RSTN), .START(START), .ABORT(ABORT), .HOLD(HOLD),
    .DIV(DIV), .BURST(BURST), .SP(SP), .BUSY(BUSY), .DONE(DONE),
    .PCNT(PCNT), .dbg_state(dbg_state)
  );

  // clock / reset block
  initial CK = 1'b0;
  always #5 CK = ~CK;
  always @(posedge CK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CK);
    #1;
  endtask

  // monitor: every SP cycle must match the next predicted pulse
  always @(negedge CK) begin
    logic [RW-1:0] rec;
    if (SP === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_sp at cycle %0d: got SP=1 expected SP=0", cyc);
      end else begin
        rec = exp_q.pop_front();
        check("sp_cycle", 32'(cyc), rec[RW-1:BW+1]);
        check("sp_pcnt", 32'(PCNT), 32'(rec[BW:1]));
        check("sp_done", 32'(DONE), 32'(rec[0]));
      end
    end else begin
      check("done_without_sp", 32'(DONE), 32'd0);
    end
  end

  // One burst. Pulse n lands on the edge where the count of non-held RUN
  // edges since acceptance reaches n*(div+1). hold_mode: 0 none, 1 random,
  // 2 held at edges 3..5 after acceptance.
  task automatic run_burst(input int div, input int burst, input int abort_off, input int hold_mode);
    bit            hold[512];
    int            k, act, n, end_o;
    logic [BW-1:0] pv;
    logic          dn;
    k = cyc + 1;
    for (int i = 0; i < 512; i++) begin
      if (hold_mode == 1)      hold[i] = ($urandom_range(0, 3) == 0);
      else if (hold_mode == 2) hold[i] = (i >= 3 && i <= 5);
      else                     hold[i] = 1'b0;
    end
    act = 0;
    n = 0;
    end_o = 0;
    for (int i = 1; i < 512 && end_o == 0; i++) begin
      if (abort_off != 0 && i == abort_off) begin
        end_o = i;
      end else if (!hold[i]) begin
        act++;
        if (act % (div + 1) == 0) begin
          n++;
          pv = n[BW-1:0];
          dn = (burst != 0 && n == burst);
          exp_q.push_back({32'(k + i), pv, dn});
          if (dn) end_o = i + 1;
        end
      end
    end
    if (end_o == 0) end_o = 511;
    DIV   = CW'(div);
    BURST = BW'(burst);
    START = 1'b1;
    ABORT = 1'b0;
    HOLD  = 1'b0;
    step();
    check("busy_after_start", 32'(BUSY), 32'd1);
    for (int o = 1; o <= end_o; o++) begin
      HOLD  = hold[o];
      ABORT = (o == abort_off);
      START = 1'($urandom_range(0, 1));
      DIV   = CW'($urandom_range(0, 255));
      BURST = BW'($urandom_range(0, 15));
      step();
    end
    START = 1'b0;
    ABORT = 1'b0;
    HOLD  = 1'b0;
    check("busy_end", 32'(BUSY), 32'd0);
    check("sp_end", 32'(SP), 32'd0);
    check("done_end", 32'(DONE), 32'd0);
    check("pcnt_end", 32'(PCNT), 32'(n % (1 << BW)));
    check("pulses_missing", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    last_pcnt = n % (1 << BW);
  endtask

  task automatic start_abort_idle();
    START = 1'b1;
    ABORT = 1'b1;
    DIV   = CW'(3);
    BURST = BW'(2);
    step();
    START = 1'b0;
    ABORT = 1'b0;
    check("sa_busy", 32'(BUSY), 32'd0);
    check("sa_pcnt", 32'(PCNT), 32'(last_pcnt));
    repeat (4) step();
    check("sa_busy_later", 32'(BUSY), 32'd0);
  endtask

  task automatic reset_mid_burst();
    int k;
    k = cyc + 1;
    exp_q.push_back({32'(k + 4), BW'(1), 1'b0});
    exp_q.push_back({32'(k + 8), BW'(2), 1'b0});
    DIV   = CW'(3);
    BURST = BW'(5);
    START = 1'b1;
    step();
    START = 1'b0;
    repeat (8) step();
    @(negedge CK);
    #1;
    RSTN = 1'b0;
    #1;
    check("rst_sp", 32'(SP), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_done", 32'(DONE), 32'd0);
    check("rst_pcnt", 32'(PCNT), 32'd0);
    repeat (3) step();
    RSTN = 1'b1;
    repeat (10) step();
    check("rst_idle_busy", 32'(BUSY), 32'd0);
    check("rst_pulses", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    last_pcnt = 0;
  endtask

  initial begin
    int div, burst, ab, hm;
    RSTN  = 1'b0;
    START = 1'b0;
    ABORT = 1'b0;
    HOLD  = 1'b0;
    DIV   = '0;
    BURST = '0;
    repeat (3) step();
    check("reset_sp", 32'(SP), 32'd0);
    check("reset_busy", 32'(BUSY), 32'd0);
    check("reset_done", 32'(DONE), 32'd0);
    check("reset_pcnt", 32'(PCNT), 32'd0);
    RSTN = 1'b1;
    repeat (2) step();

    run_burst(2, 4, 0, 0);
    run_burst(0, 3, 0, 0);
    run_burst(0, 0, 21, 0);
    run_burst(4, 2, 0, 2);
    run_burst(2, 4, 0, 0);
    start_abort_idle();
    reset_mid_burst();
    run_burst(1, 3, 0, 0);

    for (int t = 0; t < 40; t++) begin
      div   = $urandom_range(0, 7);
      burst = $urandom_range(0, 15);
      if (burst == 0) ab = $urandom_range(1, 60);
      else            ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 60) : 0;
      hm = $urandom_range(0, 1);
      run_burst(div, burst, ab, hm);
      if ($urandom_range(0, 3) == 0) start_abort_idle();
      repeat ($urandom_range(0, 2)) step();
    end

    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
